// File: rtl/datamem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t : arbitration state (OPEN, LOCK0, LOCK1)
//   ARB_AW/ARB_DW : default address/data widths of the 256x8 data memory
package datamem_arb_pkg;

    localparam int ARB_AW = 8;
    localparam int ARB_DW = 8;

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb2_pick.sv
// Two-way winner select for the data-memory arbiter (purely combinational).
// Ports:
//   valid0, valid1 : request valids of port 0 / port 1
//   last_grant     : port of the most recent transfer (0 or 1)
//   state          : current arbitration state
//   grant[1:0]     : one-hot winner (bit N = port N), 0 when nobody wins
// Build option: DATAMEM_ARB_RR_EN selects round-robin on contention in OPEN;
// without it port 0 always wins contention.
module arb2_pick
    import datamem_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    input  arb_state_t state,
    output logic [1:0] grant
);

`ifndef DATAMEM_ARB_RR_EN
    // Fixed priority ignores the grant history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant = 2'b00;
        case (state)
            OPEN: begin
                if (valid0 && valid1) begin
`ifdef DATAMEM_ARB_RR_EN
                    // Winner is the port that did not win last time.
                    grant = last_grant ? 2'b01 : 2'b10;
`else
                    grant = 2'b01;
`endif
                end else begin
                    grant = {valid1, valid0};
                end
            end
            // The owner of a lock is the only candidate, even when idle.
            LOCK0:   grant = {1'b0, valid0};
            LOCK1:   grant = {valid1, 1'b0};
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of the single-port 256x8 data memory.
// Port 0 = core load/store unit, port 1 = auxiliary loader / DMA engine.
// Ports:
//   clock, reset_n          : clock (rising edge), async active-low reset
//   reqN_valid/write/lock   : request, 1=store/0=load, keep grant after transfer
//   reqN_addr/wdata         : access address and store data
//   reqN_ready              : request accepted this cycle
//   reqN_rvalid/rdata       : load data, valid for one cycle after the transfer
//   mem_write/addr/wdata    : drive to memory memWrite/addr/data_in
//   mem_rdata               : memory data_out (combinational read)
//   debug_state             : current arbitration state
// Build option: DATAMEM_ARB_RR_EN (round-robin contention, see arb2_pick).
//
// Handshake: a transfer happens on port N when reqN_valid & reqN_ready at a
// rising edge. The requester keeps valid/write/lock/addr/wdata stable until
// ready; ready is combinational from valid and at most one port is ready.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic          req0_lock,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic          req1_lock,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output arb_state_t    debug_state
);

    arb_state_t state, state_next;
    logic       last_grant;
    logic [1:0] grant_raw;
    logic [1:0] grant;
    logic       load0, load1;

    arb2_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .state      (state),
        .grant      (grant_raw)
    );

    // Gating with reset_n drops ready and mem_write the moment reset is
    // asserted, so no store can commit at the following edge.
    assign grant      = grant_raw & {2{reset_n}};
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign load0      = grant[0] & ~req0_write;
    assign load1      = grant[1] & ~req1_write;

    assign debug_state = state;

    always_comb begin
        state_next = state;
        case (state)
            OPEN: begin
                if (grant[0] && req0_lock) state_next = LOCK0;
                else if (grant[1] && req1_lock) state_next = LOCK1;
            end
            LOCK0:   if (grant[0] && !req0_lock) state_next = OPEN;
            LOCK1:   if (grant[1] && !req1_lock) state_next = OPEN;
            default: state_next = OPEN;
        endcase
    end

    // last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= OPEN;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (|grant) last_grant <= grant[1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            req0_rvalid <= load0;
            req1_rvalid <= load1;
            if (load0) req0_rdata <= mem_rdata;
            if (load1) req1_rdata <= mem_rdata;
        end
    end

    always_comb begin
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant[0]) begin
            mem_write = req0_write;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
        end else if (grant[1]) begin
            mem_write = req1_write;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed testbench for datamem_arbiter with a small 256x8 memory model.
module tb_datamem_arbiter;
    import datamem_arb_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       req0_valid, req0_write, req0_lock;
    logic [7:0] req0_addr, req0_wdata;
    logic       req0_ready, req0_rvalid;
    logic [7:0] req0_rdata;
    logic       req1_valid, req1_write, req1_lock;
    logic [7:0] req1_addr, req1_wdata;
    logic       req1_ready, req1_rvalid;
    logic [7:0] req1_rdata;
    logic       mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    arb_state_t debug_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    datamem_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_write  (req0_write),
        .req0_lock   (req0_lock),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req1_valid  (req1_valid),
        .req1_write  (req1_write),
        .req1_lock   (req1_lock),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .debug_state (debug_state)
    );

    // Clock / memory model
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    // Driver tasks
    task automatic drive0(input logic v, input logic w, input logic l,
                          input logic [7:0] a, input logic [7:0] d);
        req0_valid = v; req0_write = w; req0_lock = l; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic l,
                          input logic [7:0] a, input logic [7:0] d);
        req1_valid = v; req1_write = w; req1_lock = l; req1_addr = a; req1_wdata = d;
    endtask

    task automatic idle_all();
        drive0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        idle_all();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
    endtask

    // Tests
    task automatic test_reset();
        reset_n = 1'b0;
        drive0(1'b1, 1'b1, 1'b0, 8'h10, 8'hEE);
        idle_all();
        drive0(1'b1, 1'b1, 1'b0, 8'h10, 8'hEE);
        @(negedge clock);
        checks++;
        if ({req1_ready, req0_ready, mem_write} !== 3'b000) begin
            $display("FAIL reset_ready: got %b expected 000", {req1_ready, req0_ready, mem_write});
            errors++;
        end
        checks++;
        if ({req1_rvalid, req0_rvalid, req0_rdata, req1_rdata} !== 18'h0) begin
            $display("FAIL reset_rdata: got %h expected 0", {req1_rvalid, req0_rvalid, req0_rdata, req1_rdata});
            errors++;
        end
        checks++;
        if (debug_state !== OPEN) begin
            $display("FAIL reset_state: got %0d expected %0d", debug_state, OPEN);
            errors++;
        end
        next_cycle();
        idle_all();
        reset_n = 1'b1;
    endtask

    task automatic test_store_load();
        next_cycle();
        drive0(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5);
        @(negedge clock);
        checks++;
        if ({req1_ready, req0_ready, mem_write, mem_addr, mem_wdata} !== {3'b011, 8'h10, 8'hA5}) begin
            $display("FAIL store_drive: got %h expected %h",
                     {req1_ready, req0_ready, mem_write, mem_addr, mem_wdata}, {3'b011, 8'h10, 8'hA5});
            errors++;
        end
        next_cycle();
        drive0(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge clock);
        checks++;
        if ({req0_ready, mem_write, req0_rvalid} !== 3'b100) begin
            $display("FAIL load_accept: got %b expected 100", {req0_ready, mem_write, req0_rvalid});
            errors++;
        end
        next_cycle();
        idle_all();
        @(negedge clock);
        checks++;
        if ({req0_rvalid, req0_rdata} !== {1'b1, 8'hA5}) begin
            $display("FAIL load_data: got %h expected %h", {req0_rvalid, req0_rdata}, {1'b1, 8'hA5});
            errors++;
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if ({req0_rvalid, req0_rdata} !== {1'b0, 8'hA5}) begin
            $display("FAIL load_hold: got %h expected %h", {req0_rvalid, req0_rdata}, {1'b0, 8'hA5});
            errors++;
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        logic [1:0] prev;
`ifdef DATAMEM_ARB_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        // Seed data; the port 1 store leaves last_grant = 1.
        next_cycle();
        drive0(1'b1, 1'b1, 1'b0, 8'h01, 8'h11);
        next_cycle();
        idle_all();
        drive1(1'b1, 1'b1, 1'b0, 8'h02, 8'h22);
        next_cycle();
        drive1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        next_cycle();
        drive0(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
        drive1(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if ({req1_ready, req0_ready} !== exp_g[k] ||
                mem_addr !== (exp_g[k][1] ? 8'h02 : 8'h01)) begin
                $display("FAIL contend_grant%0d: got %b/%h expected %b/%h", k,
                         {req1_ready, req0_ready}, mem_addr, exp_g[k], exp_g[k][1] ? 8'h02 : 8'h01);
                errors++;
            end
            if (k > 0) begin
                checks++;
                if ({req1_rvalid, req0_rvalid} !== prev) begin
                    $display("FAIL contend_rvalid%0d: got %b expected %b", k, {req1_rvalid, req0_rvalid}, prev);
                    errors++;
                end
            end
            prev = exp_g[k];
            next_cycle();
        end
        idle_all();
        @(negedge clock);
        checks++;
        if ({req1_rvalid, req0_rvalid} !== prev ||
            (prev[0] ? req0_rdata : req1_rdata) !== (prev[0] ? 8'h11 : 8'h22)) begin
            $display("FAIL contend_last: got %b/%h/%h expected %b/%h",
                     {req1_rvalid, req0_rvalid}, req0_rdata, req1_rdata, prev, prev[0] ? 8'h11 : 8'h22);
            errors++;
        end
    endtask

    task automatic test_lock();
        next_cycle();
        drive1(1'b1, 1'b1, 1'b1, 8'h20, 8'h77);
        @(negedge clock);
        checks++;
        if ({req1_ready, req0_ready, mem_write} !== 3'b101) begin
            $display("FAIL lock_take: got %b expected 101", {req1_ready, req0_ready, mem_write});
            errors++;
        end
        next_cycle();
        drive1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive0(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if ({req1_ready, req0_ready, mem_write} !== 3'b000 || mem_addr !== 8'h00 ||
                debug_state !== LOCK1) begin
                $display("FAIL lock_hold%0d: got %b/%h/%0d expected 000/00/%0d", k,
                         {req1_ready, req0_ready, mem_write}, mem_addr, debug_state, LOCK1);
                errors++;
            end
            next_cycle();
        end
        drive1(1'b1, 1'b1, 1'b0, 8'h21, 8'h88);
        @(negedge clock);
        checks++;
        if ({req1_ready, req0_ready, mem_write} !== 3'b101 || mem_addr !== 8'h21) begin
            $display("FAIL lock_release: got %b/%h expected 101/21", {req1_ready, req0_ready, mem_write}, mem_addr);
            errors++;
        end
        next_cycle();
        drive1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        checks++;
        if ({req1_ready, req0_ready, mem_write} !== 3'b010 || mem_addr !== 8'h20 || debug_state !== OPEN) begin
            $display("FAIL lock_after: got %b/%h/%0d expected 010/20/%0d",
                     {req1_ready, req0_ready, mem_write}, mem_addr, debug_state, OPEN);
            errors++;
        end
        next_cycle();
        idle_all();
        @(negedge clock);
        checks++;
        if ({req0_rvalid, req0_rdata} !== {1'b1, 8'h77}) begin
            $display("FAIL lock_data: got %h expected %h", {req0_rvalid, req0_rdata}, {1'b1, 8'h77});
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive0(1'b1, 1'b1, 1'b0, 8'h40, 8'h33);
        drive1(1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
        @(negedge clock);
        checks++;
        if ({req1_ready, req0_ready, mem_write, mem_wdata} !== {3'b011, 8'h33}) begin
            $display("FAIL b2b_first: got %h expected %h", {req1_ready, req0_ready, mem_write, mem_wdata}, {3'b011, 8'h33});
            errors++;
        end
        next_cycle();
        drive0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        checks++;
        if ({req1_ready, req0_ready, mem_write, mem_addr} !== {3'b100, 8'h40}) begin
            $display("FAIL b2b_second: got %h expected %h", {req1_ready, req0_ready, mem_write, mem_addr}, {3'b100, 8'h40});
            errors++;
        end
        next_cycle();
        idle_all();
        @(negedge clock);
        checks++;
        if ({req1_rvalid, req1_rdata} !== {1'b1, 8'h33}) begin
            $display("FAIL b2b_data: got %h expected %h", {req1_rvalid, req1_rdata}, {1'b1, 8'h33});
            errors++;
        end
    endtask

    task automatic test_reset_mid_op();
        next_cycle();
        drive0(1'b1, 1'b1, 1'b0, 8'h50, 8'hC3);
        next_cycle();
        drive0(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        next_cycle();
        checks++;
        if (debug_state !== LOCK0 || req0_rvalid !== 1'b1) begin
            $display("FAIL midrst_pre: got %0d/%b expected %0d/1", debug_state, req0_rvalid, LOCK0);
            errors++;
        end
        drive0(1'b1, 1'b1, 1'b1, 8'h50, 8'h5A);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, mem_write, req0_rvalid} !== 3'b000 || debug_state !== OPEN) begin
            $display("FAIL midrst_now: got %b/%0d expected 000/%0d", {req0_ready, mem_write, req0_rvalid}, debug_state, OPEN);
            errors++;
        end
        @(negedge clock);
        checks++;
        if ({req0_ready, mem_write} !== 2'b00) begin
            $display("FAIL midrst_write: got %b expected 00", {req0_ready, mem_write});
            errors++;
        end
        next_cycle();
        reset_n = 1'b1;
        idle_all();
        next_cycle();
        drive0(1'b1, 1'b0, 1'b0, 8'h50, 8'h00);
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b1 || debug_state !== OPEN) begin
            $display("FAIL midrst_open: got %b/%0d expected 1/%0d", req0_ready, debug_state, OPEN);
            errors++;
        end
        next_cycle();
        idle_all();
        @(negedge clock);
        checks++;
        if ({req0_rvalid, req0_rdata} !== {1'b1, 8'hC3}) begin
            $display("FAIL midrst_data: got %h expected %h", {req0_rvalid, req0_rdata}, {1'b1, 8'hC3});
            errors++;
        end
    endtask

    task automatic test_idle();
        idle_all();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clock);
            checks++;
            if ({req1_ready, req0_ready, req1_rvalid, req0_rvalid, mem_write, mem_addr, mem_wdata} !== 21'h0) begin
                $display("FAIL idle%0d: got %h expected 0", k,
                         {req1_ready, req0_ready, req1_rvalid, req0_rvalid, mem_write, mem_addr, mem_wdata});
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_contention();
        test_lock();
        test_back_to_back();
        test_reset_mid_op();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
